// File: rtl/sram_parity_ctrl.sv
// Request-side SRAM controller: init sweep, per-byte even parity held in flops, read checking and error logging.
// Optional SRAM_PARITY_ERR_INJECT_EN adds inj_i, which flips bit 0 of a read's data to force a parity error.
module sram_parity_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 1024,
    parameter int CNT_WIDTH  = 16,
    localparam int AW        = $clog2(NUM_WORDS),
    localparam int NB        = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [NB-1:0]         be_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rerr_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [NB-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    output logic                  init_done_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic [AW-1:0]         err_addr_o,
    output logic                  err_irq_o,
`ifdef SRAM_PARITY_ERR_INJECT_EN
    input  logic                  inj_i,
`endif
    input  logic                  err_clr_i
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         sweep_q;
    logic [NB-1:0]         parity_q [NUM_WORDS];
    logic                  rd_pend_q;
    logic [AW-1:0]         rd_addr_q;
    logic [NB-1:0]         rd_par_q;
    logic [NB-1:0]         rd_par_now;
    logic [DATA_WIDTH-1:0] rdata_fix;
    logic                  rd_go;
    logic                  wr_go;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                sweep_q <= sweep_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_o        = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = addr_i;
        sram_wdata_o = wdata_i;
        sram_be_o    = be_i;
        case (state_q)
            INIT: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = sweep_q;
                sram_wdata_o = '0;
                sram_be_o    = '1;
                if (sweep_q == AW'(NUM_WORDS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                gnt_o      = req_i;
                sram_req_o = req_i;
                sram_we_o  = we_i;
            end
            default: state_d = INIT;
        endcase
    end

    assign init_done_o = (state_q == RUN);
    assign rd_go       = gnt_o & req_i & ~we_i;
    assign wr_go       = gnt_o & req_i & we_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                parity_q[i] <= '0;
            end
        end else if (wr_go) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    parity_q[addr_i][b] <= ^wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Parity row is snapshotted at grant so a write right behind the read cannot disturb the check.
`ifdef SRAM_PARITY_ERR_INJECT_EN
    logic inj_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inj_q <= 1'b0;
        end else if (rd_go) begin
            inj_q <= inj_i;
        end
    end

    assign rdata_fix = sram_rdata_i ^ {{(DATA_WIDTH-1){1'b0}}, inj_q};
`else
    assign rdata_fix = sram_rdata_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            rd_par_q  <= '0;
        end else begin
            rd_pend_q <= rd_go;
            if (rd_go) begin
                rd_addr_q <= addr_i;
                rd_par_q  <= parity_q[addr_i];
            end
        end
    end

    always_comb begin
        rd_par_now = '0;
        for (int b = 0; b < NB; b++) begin
            rd_par_now[b] = ^rdata_fix[8*b +: 8];
        end
    end

    assign rvalid_o = rd_pend_q;
    assign rdata_o  = rdata_fix;
    assign rerr_o   = rd_pend_q & (rd_par_now != rd_par_q);

    // Clear has priority over a coincident error; the interrupt still fires.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_irq_o  <= 1'b0;
            err_cnt_o  <= '0;
            err_addr_o <= '0;
        end else begin
            err_irq_o <= rerr_o;
            if (err_clr_i) begin
                err_cnt_o  <= '0;
                err_addr_o <= '0;
            end else if (rerr_o) begin
                err_addr_o <= rd_addr_q;
                if (err_cnt_o != '1) begin
                    err_cnt_o <= err_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule
